// File: rtl/mmio_io_pkg.sv
// mmio_io_pkg: shared definitions for the memory-mapped I/O controller.
//   - Word offsets of the four registers inside the I/O window.
//   - Bit positions inside the STATUS register.
//   - A decoded-access record used by the top level.
package mmio_io_pkg;

  // Register offsets (memAddress[1:0]) inside the 4-word window
  localparam logic [1:0] OFF_LED      = 2'd0;
  localparam logic [1:0] OFF_SW       = 2'd1;
  localparam logic [1:0] OFF_BTN_EDGE = 2'd2;
  localparam logic [1:0] OFF_STATUS   = 2'd3;

  // STATUS register bit positions
  localparam int STATUS_SW_IDLE_BIT  = 0;
  localparam int STATUS_BTN_PEND_BIT = 1;

  // One decoded CPU access to the window
  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [1:0] off;
  } io_access_t;

endpackage

// File: rtl/io_debounce.sv
// io_debounce: two-flop synchroniser plus per-bit debounce counter.
//   clk, rst : clock and synchronous active-high reset
//   din      : raw asynchronous inputs (W bits)
//   stable   : debounced value, registered
//   idle     : 1 when no bit has a pending change (synchronised == stable)
// A bit only changes once the synchronised value has differed from the
// accepted value for DEBOUNCE_CYCLES consecutive cycles.
module io_debounce #(
  parameter int W               = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable,
  output logic         idle
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     sync1_r;
  logic [W-1:0]     sync2_r;
  logic [W-1:0]     stable_r;
  logic [CNT_W-1:0] cnt_r [W];

  // Two-flop synchroniser for the raw inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // Per-bit counter: runs while the input disagrees, commits at CNT_MAX
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_r <= '0;
      for (int i = 0; i < W; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (sync2_r[i] != stable_r[i]) begin
          if (cnt_r[i] == CNT_MAX) begin
            stable_r[i] <= sync2_r[i];
            cnt_r[i]    <= '0;
          end else begin
            cnt_r[i] <= cnt_r[i] + CNT_W'(1);
          end
        end else begin
          cnt_r[i] <= '0;
        end
      end
    end
  end

  assign stable = stable_r;
  assign idle   = (sync2_r == stable_r);

endmodule

// File: rtl/mmio_io_controller.sv
// mmio_io_controller: memory-mapped I/O between the CPU data port and the
// board switches, buttons and LEDs.
//   clk, rst     : clock and synchronous active-high reset
//   memAddress   : CPU word address; window is BASE_WADDR..BASE_WADDR+3
//   writeData    : CPU store data
//   writeEnable  : single-cycle store strobe
//   readEnable   : single-cycle load strobe
//   switches     : raw switch inputs (IO_W)
//   btns         : raw button inputs (IO_W)
//   readData     : registered load data, one cycle after the load
//   readValid    : one-cycle pulse marking readData valid
//   ioHit        : combinational window hit for the CPU data mux
//   busErr       : registered one-cycle pulse on an illegal access
//   leds         : registered LED drive
module mmio_io_controller
  import mmio_io_pkg::*;
#(
  parameter logic [29:0] BASE_WADDR      = 30'h0000_0100,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          IO_W            = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [29:0]     memAddress,
  input  logic [31:0]     writeData,
  input  logic            writeEnable,
  input  logic            readEnable,
  input  logic [IO_W-1:0] switches,
  input  logic [IO_W-1:0] btns,
  output logic [31:0]     readData,
  output logic            readValid,
  output logic            ioHit,
  output logic            busErr,
  output logic [IO_W-1:0] leds
);

  io_access_t      acc_s;
  logic [IO_W-1:0] sw_stable_s;
  logic            sw_idle_s;
  logic [IO_W-1:0] btn_stable_s;
  logic            btn_idle_s;
  logic [IO_W-1:0] rise_s;
  logic [IO_W-1:0] clr_s;
  logic [IO_W-1:0] edge_next_s;
  logic [31:0]     status_s;
  logic [31:0]     rd_mux_s;
  logic            unused_s;

  logic [IO_W-1:0] leds_r;
  logic [IO_W-1:0] edge_r;
  logic [IO_W-1:0] btn_prev_r;
  logic [31:0]     read_data_r;
  logic            read_valid_r;
  logic            bus_err_r;

  io_debounce #(.W(IO_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk    (clk),
    .rst    (rst),
    .din    (switches),
    .stable (sw_stable_s),
    .idle   (sw_idle_s)
  );

  io_debounce #(.W(IO_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk    (clk),
    .rst    (rst),
    .din    (btns),
    .stable (btn_stable_s),
    .idle   (btn_idle_s)
  );

  // Button idle and the upper store bits have no consumer here
  assign unused_s = &{1'b0, writeData, btn_idle_s};

  assign ioHit     = (memAddress[29:2] == BASE_WADDR[29:2]);
  assign acc_s.rd  = readEnable && ioHit;
  assign acc_s.wr  = writeEnable && ioHit;
  assign acc_s.off = memAddress[1:0];

  assign rise_s = btn_stable_s & ~btn_prev_r;

  // Clear mask for the sticky edge flags: read clears all, write-1 clears selected
  always_comb begin
    clr_s = '0;
    if (acc_s.rd && (acc_s.off == OFF_BTN_EDGE)) begin
      clr_s = '1;
    end else if (acc_s.wr && (acc_s.off == OFF_BTN_EDGE)) begin
      clr_s = writeData[IO_W-1:0];
    end else begin
      clr_s = '0;
    end
  end

  // A new edge overrides a clear landing in the same cycle
  assign edge_next_s = (edge_r & ~clr_s) | rise_s;

  // STATUS word assembly
  always_comb begin
    status_s                      = 32'h0000_0000;
    status_s[STATUS_SW_IDLE_BIT]  = sw_idle_s;
    status_s[STATUS_BTN_PEND_BIT] = |edge_r;
  end

  // Read mux uses current (pre-write) register values
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (acc_s.off)
      OFF_LED:      rd_mux_s = 32'(leds_r);
      OFF_SW:       rd_mux_s = 32'(sw_stable_s);
      OFF_BTN_EDGE: rd_mux_s = 32'(edge_r);
      OFF_STATUS:   rd_mux_s = status_s;
      default:      rd_mux_s = 32'h0000_0000;
    endcase
  end

  // LED register, loaded by a store to offset 0
  always_ff @(posedge clk) begin
    if (rst) begin
      leds_r <= '0;
    end else if (acc_s.wr && (acc_s.off == OFF_LED)) begin
      leds_r <= writeData[IO_W-1:0];
    end else begin
      leds_r <= leds_r;
    end
  end

  // Sticky button edge flags and the previous debounced value for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_r     <= '0;
      btn_prev_r <= '0;
    end else begin
      edge_r     <= edge_next_s;
      btn_prev_r <= btn_stable_s;
    end
  end

  // Registered read response and illegal-store pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_r  <= 32'h0000_0000;
      read_valid_r <= 1'b0;
      bus_err_r    <= 1'b0;
    end else begin
      read_valid_r <= acc_s.rd;
      bus_err_r    <= acc_s.wr && (acc_s.off == OFF_STATUS);
      if (acc_s.rd) begin
        read_data_r <= rd_mux_s;
      end else begin
        read_data_r <= read_data_r;
      end
    end
  end

  assign leds      = leds_r;
  assign readData  = read_data_r;
  assign readValid = read_valid_r;
  assign busErr    = bus_err_r;

endmodule
